seven_segment_counter_mux: RTL and testbench
============================================

# seven_segment_counter_mux

Parametrised successor to the single-digit seven-segment seconds counter. It holds a NUM_DIGITS-wide BCD counter advanced by a programmable prescaler, with up, down, hold and clear modes, and time-multiplexes the digits onto one shared 7-segment bus. It sits behind a project slot in the multi-project harness. The harness drives `compare_in` and `mode_in` from the Wishbone data bus and pulses the update strobes on a matching Wishbone write.

## Interface
Parameters:
- `NUM_DIGITS`, default 4: number of BCD digits, legal range 1–8.
- `COMPARE_W`, default 24: prescaler and compare register width.
- `DEFAULT_COMPARE`, default 16_000_000: compare value loaded at reset.
- `SCAN_DIV_W`, default 10: digit scan advances every 2^SCAN_DIV_W clocks.

Ports:
- `clk`, in, 1: single clock; all state is on its rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `compare_in`, in, COMPARE_W: new prescaler compare value.
- `update_compare`, in, 1: one-cycle strobe; loads `compare_in`.
- `mode_in`, in, 2: new count mode.
- `update_mode`, in, 1: one-cycle strobe; loads `mode_in`.
- `led_out`, out, 7: segments {g,f,e,d,c,b,a}, active high, registered.
- `digit_en`, out, NUM_DIGITS: one-hot active-high digit select, registered.
- `wrap`, out, 1: one-cycle pulse on counter roll-over or roll-under, registered.

## Operation
- Prescaler:
  - Counts 0..compare−1. At compare−1 it asserts an internal `tick` for one cycle and returns to 0.
  - A compare value of 0 is treated as 1, so `tick` fires every cycle.
- Compare load: `update_compare` loads `compare_in` and clears the prescaler to 0 in the same cycle. No tick is issued in that cycle, even if one was due.
- Modes, held in the mode register:
  - 00 UP: count increments by 1 per tick.
  - 01 DOWN: count decrements by 1 per tick.
  - 10 HOLD: ticks are ignored.
  - 11 CLEAR: count is forced to 0 every cycle; no wrap pulse.
- Counter: NUM_DIGITS BCD decades, ripple carry/borrow within one cycle.
  - UP: 9…9 → 0…0 and `wrap` pulses.
  - DOWN: 0…0 → 9…9 and `wrap` pulses.
- Mode change timing: on a tick, the mode register value before the clock edge governs the count. An `update_mode` in the same cycle as a tick takes effect from the next tick.
- Scan:
  - A SCAN_DIV_W-bit free-running counter; its all-ones state advances the digit index 0→1→…→NUM_DIGITS−1→0.
  - `digit_en[index]`=1 and `led_out`=segments(digit[index]).
  - The scan is independent of the prescaler and of the mode.
- Segment codes, digits 0–9: 3F 06 5B 4F 66 6D 7D 07 7F 6F. A non-BCD value (unreachable) decodes to 00.

## Timing
- Reset values:
  - count 0, compare DEFAULT_COMPARE, mode UP, prescaler 0.
  - scan counter 0, index 0.
  - `digit_en`=1 (digit 0), `led_out`=3F, `wrap`=0.
- With compare=C after a load, the first tick occurs C cycles after the `update_compare` cycle.
- The count register changes on the edge ending the tick cycle.
- `led_out` and `digit_en` change on the same edge, one cycle after the index or displayed digit changes. They are never mutually inconsistent.
- `wrap` is high in the cycle after the wrapping tick, for exactly one cycle.
- `update_compare` and `update_mode` in the same cycle are both applied.
- Asserting `reset_n` mid-count returns all state to the reset values immediately, independent of `clk`.
- With NUM_DIGITS=1, `digit_en` is constantly 1.

## Structure
- Package `seven_seg_pkg`:
  - Mode enum: UP, DOWN, HOLD, CLEAR.
  - 7-bit segment constants plus a `bcd_to_seg` function.
  - Parameter legality check for NUM_DIGITS ∈ 1–8.
- Sub-module `bcd_digit`: one decade counter with enable, up/down, clear, carry/borrow-in and carry/borrow-out. Generated NUM_DIGITS times.
- The top level holds the prescaler, the mode and compare registers, the scan logic and the output registers.

## Test plan
- Reset, then NUM_DIGITS=4, compare=3, UP → a tick every 3 cycles; digits read 0001, 0002, …; `wrap` stays 0.
- Preload to 9999 via UP, then one more tick → 0000, `wrap`=1 for one cycle. Then DOWN and one tick → 9999 with a `wrap` pulse.
- `update_compare` asserted in the cycle a tick is due → no increment; the next tick follows exactly the new compare value of cycles later. Also compare=0 → increments every cycle.
- HOLD for 50 ticks → count unchanged. CLEAR → 0000 the next cycle. UP again resumes from 0001.
- SCAN_DIV_W=2, count 1234 → `digit_en` rotates 0001, 0010, 0100, 1000 every 4 cycles. `led_out` shows 66, 4F, 5B, 06 (digit 0 is least significant) in lockstep.
- Assert `reset_n` low mid-count, asynchronously between edges → outputs go to the reset values immediately; the count restarts from 0000.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared types, segment encodings and parameter checks for the seven-segment counter.
package seven_seg_pkg;

    localparam int unsigned SEG_W      = 7;
    localparam int unsigned BCD_W      = 4;
    localparam int unsigned MODE_W     = 2;
    localparam int unsigned MIN_DIGITS = 1;
    localparam int unsigned MAX_DIGITS = 8;

    typedef enum logic [MODE_W-1:0] {
        MODE_UP    = 2'b00,
        MODE_DOWN  = 2'b01,
        MODE_HOLD  = 2'b10,
        MODE_CLEAR = 2'b11
    } mode_e;

    // Segment order is {g,f,e,d,c,b,a}, active high
    localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
    localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
    localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
    localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
    localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

    // Decode one BCD digit; anything outside 0-9 blanks the display
    function automatic logic [SEG_W-1:0] bcd_to_seg(input logic [BCD_W-1:0] bcd);
        logic [SEG_W-1:0] seg;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    // Digit count must fit the one-hot select and the scan index
    function automatic bit num_digits_legal(input int unsigned n);
        return (n >= MIN_DIGITS) && (n <= MAX_DIGITS);
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade with enable, up/down, synchronous clear and ripple carry/borrow.
module bcd_digit
    import seven_seg_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             down,
    input  logic             clear,
    input  logic             cin,
    output logic [BCD_W-1:0] digit,
    output logic             cout_c
);

    logic             step_c;
    logic             at_limit_c;
    logic [BCD_W-1:0] digit_next_c;

    // A decade steps only when the tick is live and every lower decade is at its limit
    assign step_c     = en & cin;
    assign at_limit_c = down ? (digit == BCD_W'(0)) : (digit == BCD_W'(9));
    assign cout_c     = step_c & at_limit_c;

    // Next digit value: clear dominates, then wrap-around step
    always_comb begin
        digit_next_c = digit;
        if (clear) begin
            digit_next_c = '0;
        end else if (step_c) begin
            if (down) begin
                digit_next_c = at_limit_c ? BCD_W'(9) : digit - BCD_W'(1);
            end else begin
                digit_next_c = at_limit_c ? BCD_W'(0) : digit + BCD_W'(1);
            end
        end
    end

    // Digit register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit <= '0;
        end else begin
            digit <= digit_next_c;
        end
    end

endmodule

// File: rtl/seven_segment_counter_mux.sv
// Multi-digit BCD counter with programmable prescaler and multiplexed 7-segment output.
module seven_segment_counter_mux
    import seven_seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS      = 4,
    parameter int unsigned COMPARE_W       = 24,
    parameter int unsigned DEFAULT_COMPARE = 16_000_000,
    parameter int unsigned SCAN_DIV_W      = 10
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [COMPARE_W-1:0]  compare_in,
    input  logic                  update_compare,
    input  logic [MODE_W-1:0]     mode_in,
    input  logic                  update_mode,
    output logic [SEG_W-1:0]      led_out,
    output logic [NUM_DIGITS-1:0] digit_en,
    output logic                  wrap
);

    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    // Reject digit counts the one-hot select cannot represent
    generate
        if (!num_digits_legal(NUM_DIGITS)) begin : g_bad_num_digits
            $error("seven_segment_counter_mux: NUM_DIGITS must be within 1..8");
        end
    endgenerate

    logic [COMPARE_W-1:0]              compare_q;
    logic [COMPARE_W-1:0]              presc_q;
    mode_e                             mode_q;
    logic [SCAN_DIV_W-1:0]             scan_q;
    logic [IDX_W-1:0]                  idx_q;
    logic [NUM_DIGITS-1:0][BCD_W-1:0]  digit_q;
    logic [NUM_DIGITS:0]               carry_c;

    logic [COMPARE_W-1:0]              cmp_eff_c;
    logic [COMPARE_W-1:0]              presc_last_c;
    logic                              tick_c;
    logic                              count_en_c;
    logic                              count_down_c;
    logic                              count_clear_c;
    logic                              scan_step_c;
    logic [IDX_W-1:0]                  idx_next_c;
    logic [BCD_W-1:0]                  sel_digit_c;

    // Prescaler terminal value; a zero compare behaves as one so every cycle ticks
    assign cmp_eff_c    = (compare_q == '0) ? COMPARE_W'(1) : compare_q;
    assign presc_last_c = cmp_eff_c - COMPARE_W'(1);

    // A compare load restarts the period, so it swallows a tick that was due
    assign tick_c = (presc_q == presc_last_c) && !update_compare;

    // Count controls come from the mode held before the edge
    assign count_en_c    = tick_c && ((mode_q == MODE_UP) || (mode_q == MODE_DOWN));
    assign count_down_c  = (mode_q == MODE_DOWN);
    assign count_clear_c = (mode_q == MODE_CLEAR);

    // Prescaler, compare and mode registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            compare_q <= COMPARE_W'(DEFAULT_COMPARE);
            presc_q   <= '0;
            mode_q    <= MODE_UP;
        end else begin
            if (update_compare) begin
                compare_q <= compare_in;
                presc_q   <= '0;
            end else if (presc_q >= presc_last_c) begin
                presc_q   <= '0;
            end else begin
                presc_q   <= presc_q + COMPARE_W'(1);
            end
            if (update_mode) begin
                mode_q <= mode_e'(mode_in);
            end
        end
    end

    // BCD decade chain, least significant decade first
    assign carry_c[0] = 1'b1;

    generate
        for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
            bcd_digit u_digit (
                .clk    (clk),
                .rst_n  (reset_n),
                .en     (count_en_c),
                .down   (count_down_c),
                .clear  (count_clear_c),
                .cin    (carry_c[g]),
                .digit  (digit_q[g]),
                .cout_c (carry_c[g+1])
            );
        end
    endgenerate

    // Scan index advance on the all-ones state of the free-running divider
    assign scan_step_c = &scan_q;

    always_comb begin
        idx_next_c = idx_q;
        if (scan_step_c) begin
            if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
                idx_next_c = '0;
            end else begin
                idx_next_c = idx_q + IDX_W'(1);
            end
        end
    end

    // Scan divider and digit index registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scan_q <= '0;
            idx_q  <= '0;
        end else begin
            scan_q <= scan_q + SCAN_DIV_W'(1);
            idx_q  <= idx_next_c;
        end
    end

    // Select the digit under the current scan index
    always_comb begin
        sel_digit_c = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_digit_c = digit_q[i];
            end
        end
    end

    // Output registers: select and segments sample the same index, so they stay in step
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            led_out  <= SEG_0;
            digit_en <= NUM_DIGITS'(1);
            wrap     <= 1'b0;
        end else begin
            led_out  <= bcd_to_seg(sel_digit_c);
            digit_en <= NUM_DIGITS'(1) << idx_q;
            wrap     <= carry_c[NUM_DIGITS];
        end
    end

endmodule

// File: tb/tb_seven_segment_counter_mux.sv
// Directed bench for seven_segment_counter_mux: count modes, prescaler, scan and reset.
module tb_seven_segment_counter_mux;

    localparam int unsigned NUM_DIGITS      = 4;
    localparam int unsigned COMPARE_W       = 24;
    localparam int unsigned DEFAULT_COMPARE = 1000;
    localparam int unsigned SCAN_DIV_W      = 2;

    localparam logic [1:0] M_UP    = 2'b00;
    localparam logic [1:0] M_DOWN  = 2'b01;
    localparam logic [1:0] M_HOLD  = 2'b10;
    localparam logic [1:0] M_CLEAR = 2'b11;

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic [COMPARE_W-1:0]  compare_in;
    logic                  update_compare;
    logic [1:0]            mode_in;
    logic                  update_mode;
    logic [6:0]            led_out;
    logic [NUM_DIGITS-1:0] digit_en;
    logic                  wrap;

    int n_vec = 0;
    int n_bad = 0;
    int wrap_cnt = 0;

    seven_segment_counter_mux #(
        .NUM_DIGITS      (NUM_DIGITS),
        .COMPARE_W       (COMPARE_W),
        .DEFAULT_COMPARE (DEFAULT_COMPARE),
        .SCAN_DIV_W      (SCAN_DIV_W)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .compare_in     (compare_in),
        .update_compare (update_compare),
        .mode_in        (mode_in),
        .update_mode    (update_mode),
        .led_out        (led_out),
        .digit_en       (digit_en),
        .wrap           (wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic int seg_to_bcd(input logic [6:0] s);
        case (s)
            7'h3F:   return 0;
            7'h06:   return 1;
            7'h5B:   return 2;
            7'h4F:   return 3;
            7'h66:   return 4;
            7'h6D:   return 5;
            7'h7D:   return 6;
            7'h07:   return 7;
            7'h7F:   return 8;
            7'h6F:   return 9;
            default: return -1;
        endcase
    endfunction

    // Advance one clock, tallying cycles where wrap is high
    task automatic next_cycle();
        if (wrap) wrap_cnt++;
        @(posedge clk);
        #1;
    endtask

    // Reassemble the displayed count from one full scan frame; -1 if the display is malformed
    task automatic read_count(output int val);
        int d[NUM_DIGITS];
        bit bad;
        bad = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) d[i] = -1;
        repeat (20) begin
            if (!$onehot(digit_en)) bad = 1'b1;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (digit_en[i]) begin
                    d[i] = seg_to_bcd(led_out);
                    if (d[i] < 0) bad = 1'b1;
                end
            end
            @(posedge clk);
            #1;
        end
        val = 0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (d[i] < 0) bad = 1'b1;
            val = val * 10 + d[i];
        end
        if (bad) val = -1;
    endtask

    // Cycle 0: load compare c1 and mode m1 together. Optional compare reload c2 in
    // reload_cyc, HOLD strobe in hold_cyc, then check displayed count and wrap pulses.
    task automatic seq(input int c1, input logic [1:0] m1, input int reload_cyc, input int c2,
                       input int hold_cyc, input int exp_val, input int exp_wraps, input string tag);
        int val;
        wrap_cnt       = 0;
        compare_in     = COMPARE_W'(c1);
        update_compare = 1'b1;
        mode_in        = m1;
        update_mode    = 1'b1;
        @(posedge clk);
        #1;
        update_compare = 1'b0;
        update_mode    = 1'b0;
        for (int cyc = 1; cyc <= hold_cyc; cyc++) begin
            if (cyc == reload_cyc) begin
                compare_in     = COMPARE_W'(c2);
                update_compare = 1'b1;
            end
            if (cyc == hold_cyc) begin
                mode_in     = M_HOLD;
                update_mode = 1'b1;
            end
            next_cycle();
            update_compare = 1'b0;
            update_mode    = 1'b0;
        end
        repeat (2) next_cycle();
        read_count(val);
        check({tag, "_count"}, val, exp_val);
        check({tag, "_wrap"}, wrap_cnt, exp_wraps);
    endtask

    // k ticks at compare c in mode m, then freeze with HOLD
    task automatic run(input int c, input int k, input logic [1:0] m,
                       input int exp_val, input int exp_wraps, input string tag);
        int per;
        per = (c == 0) ? 1 : c;
        seq(c, m, 0, 0, k * per, exp_val, exp_wraps, tag);
    endtask

    int  val;
    bit  found;
    logic [NUM_DIGITS-1:0] prev_en;
    logic [6:0] scan_seg [NUM_DIGITS];

    initial begin
        reset_n        = 1'b0;
        compare_in     = '0;
        update_compare = 1'b0;
        mode_in        = M_UP;
        update_mode    = 1'b0;
        scan_seg[0] = 7'h66;
        scan_seg[1] = 7'h4F;
        scan_seg[2] = 7'h5B;
        scan_seg[3] = 7'h06;

        repeat (3) @(posedge clk);
        #1;
        check("rst_digit_en", int'(digit_en), 1);
        check("rst_led", int'(led_out), 'h3F);
        check("rst_wrap", int'(wrap), 0);
        reset_n = 1'b1;
        read_count(val);
        check("rst_count", val, 0);

        run(3, 5, M_UP, 5, 0, "up_c3_5");
        run(3, 2, M_UP, 7, 0, "up_c3_2");
        run(1, 50, M_HOLD, 7, 0, "hold50");
        run(5, 2, M_CLEAR, 0, 0, "clear");
        run(3, 1, M_UP, 1, 0, "resume");
        run(0, 9998, M_UP, 9999, 0, "c0_to_9999");
        run(2, 1, M_UP, 0, 1, "rollover");
        run(2, 1, M_DOWN, 9999, 1, "rollunder");
        run(4, 3, M_DOWN, 9996, 0, "down3");
        seq(4, M_UP, 8, 5, 13, 9998, 0, "reload_hit");
        seq(4, M_UP, 8, 5, 12, 9999, 0, "reload_early");
        run(7, 2, M_CLEAR, 0, 0, "clear2");
        run(0, 1234, M_UP, 1234, 0, "to1234");

        // Scan rotation: sync to the cycle digit 0 becomes active, then one frame
        found   = 1'b0;
        prev_en = digit_en;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk);
            #1;
            if (digit_en == NUM_DIGITS'(1) && prev_en != NUM_DIGITS'(1)) found = 1'b1;
            prev_en = digit_en;
        end
        check("scan_sync", int'(found), 1);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("scan_en_%0d", i), int'(digit_en), 1 << (i / 4));
            check($sformatf("scan_led_%0d", i), int'(led_out), int'(scan_seg[i / 4]));
            @(posedge clk);
            #1;
        end

        // Asynchronous reset while counting with the display on digit 2
        compare_in     = COMPARE_W'(2);
        update_compare = 1'b1;
        mode_in        = M_UP;
        update_mode    = 1'b1;
        @(posedge clk);
        #1;
        update_compare = 1'b0;
        update_mode    = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (digit_en == NUM_DIGITS'(4)) found = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        check("pre_rst_en", int'(digit_en), 4);
        check("pre_rst_led", int'(led_out), 'h5B);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_en", int'(digit_en), 1);
        check("async_rst_led", int'(led_out), 'h3F);
        check("async_rst_wrap", int'(wrap), 0);
        #2;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        read_count(val);
        check("post_rst_count", val, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
